// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared yCPU defines used by the EX/MEM pipeline register.
package ex_mem_pipe_pkg;
   localparam logic        RstEnable    = 1'b0;
   localparam logic        RstDisable   = 1'b1;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr   = 5'b00000;
   localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
endpackage

// File: rtl/ex_mem_pipe_dff.sv
// pipe_dff: width-parametrised register with sync active-low reset, clear and enable.
module pipe_dff
   import ex_mem_pipe_pkg::*;
#(
   parameter int          W    = 1,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst == RstEnable || clr) q <= INIT;
      else if (en) q <= d;
   end
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with hold, bubble, flush and
// MADD/MSUB accumulator feedback to EX, plus a saturating bubble counter.
module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 8,
   parameter int CNT_W      = 2,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_ex,
   input  logic                  stall_mem,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic                  ex_whilo,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   ex_hilo_temp,
   input  logic [CNT_W-1:0]      ex_cnt,
   output logic                  mem_valid,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic                  mem_whilo,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic [2*DATA_W-1:0]   hilo_temp_o,
   output logic [CNT_W-1:0]      cnt_o,
   output logic [PERF_W-1:0]     bubble_count
);
   localparam int WB_W = 1 + REG_ADDR_W + 1 + DATA_W;
   localparam int HL_W = 1 + 2 * DATA_W;
   localparam int MO_W = ALUOP_W + 2 * DATA_W;
   localparam int FB_W = 2 * DATA_W + CNT_W;
   localparam logic [WB_W-1:0] WB_INIT = {WriteDisable, REG_ADDR_W'(NOPRegAddr), WriteDisable, DATA_W'(ZeroWord)};
   localparam logic [HL_W-1:0] HL_INIT = {WriteDisable, DATA_W'(ZeroWord), DATA_W'(ZeroWord)};
   localparam logic [MO_W-1:0] MO_INIT = {ALUOP_W'(EXE_NOP_OP), DATA_W'(ZeroWord), DATA_W'(ZeroWord)};
   logic bubble, advance, mem_clr, fb_clr;
   // stall_mem alone (legal or not) means hold; flush outranks every stall.
   assign bubble  = stall_ex && !stall_mem && !flush;
   assign advance = !stall_ex && !stall_mem && !flush;
   assign mem_clr = flush || bubble;
   assign fb_clr  = flush || advance;
   pipe_dff #(.W(WB_W), .INIT(WB_INIT)) u_wb (
      .clk(clk), .rst(rst), .clr(mem_clr), .en(advance),
      .d({ex_valid, ex_wd, ex_wreg, ex_wdata}),
      .q({mem_valid, mem_wd, mem_wreg, mem_wdata})
   );
   pipe_dff #(.W(HL_W), .INIT(HL_INIT)) u_hilo (
      .clk(clk), .rst(rst), .clr(mem_clr), .en(advance),
      .d({ex_whilo, ex_hi, ex_lo}),
      .q({mem_whilo, mem_hi, mem_lo})
   );
   pipe_dff #(.W(MO_W), .INIT(MO_INIT)) u_memop (
      .clk(clk), .rst(rst), .clr(mem_clr), .en(advance),
      .d({ex_aluop, ex_mem_addr, ex_reg2}),
      .q({mem_aluop, mem_mem_addr, mem_reg2})
   );
   pipe_dff #(.W(FB_W)) u_fb (
      .clk(clk), .rst(rst), .clr(fb_clr), .en(bubble),
      .d({ex_hilo_temp, ex_cnt}),
      .q({hilo_temp_o, cnt_o})
   );
   always_ff @(posedge clk) begin
      if (rst == RstEnable) bubble_count <= '0;
      else if (bubble && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
   end
   ex_mem_pipe_stall_order: assert property (@(posedge clk) disable iff (rst == RstEnable)
      !(stall_mem && !stall_ex && !flush));
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed checks of reset, advance, bubble feedback, hold,
// flush priority and bubble-counter saturation.
module tb_ex_mem_pipe;
   logic        clk = 1'b0;
   logic        rst, stall_ex, stall_mem, flush, ex_valid, ex_wreg, ex_whilo;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
   logic [7:0]  ex_aluop;
   logic [63:0] ex_hilo_temp;
   logic [1:0]  ex_cnt;
   logic        mem_valid, mem_wreg, mem_whilo;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
   logic [7:0]  mem_aluop;
   logic [63:0] hilo_temp_o;
   logic [1:0]  cnt_o;
   logic [15:0] bubble_count;
   logic        s_valid, s_wreg, s_whilo;
   logic [4:0]  s_wd;
   logic [31:0] s_wdata, s_hi, s_lo, s_addr, s_reg2;
   logic [7:0]  s_aluop;
   logic [63:0] s_hilo;
   logic [1:0]  s_cnt;
   logic [1:0]  s_bubble;
   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   ex_mem_pipe dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
      .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o),
      .cnt_o(cnt_o), .bubble_count(bubble_count)
   );

   ex_mem_pipe #(.PERF_W(2)) dut_sat (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
      .mem_valid(s_valid), .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
      .mem_hi(s_hi), .mem_lo(s_lo), .mem_whilo(s_whilo), .mem_aluop(s_aluop),
      .mem_mem_addr(s_addr), .mem_reg2(s_reg2), .hilo_temp_o(s_hilo),
      .cnt_o(s_cnt), .bubble_count(s_bubble)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
      ex_valid = 1'b1; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
      ex_hi = 32'h1; ex_lo = 32'h2; ex_whilo = 1'b1; ex_aluop = 8'h11;
      ex_mem_addr = 32'h40; ex_reg2 = 32'h77; ex_hilo_temp = 64'h99; ex_cnt = 2'd3;
      step(2);
      check("rst_wdata", mem_wdata, 0);
      check("rst_wd", mem_wd, 0);
      check("rst_valid", mem_valid, 0);
      check("rst_wreg", mem_wreg, 0);
      check("rst_aluop", mem_aluop, 0);
      check("rst_hilo_temp", hilo_temp_o, 0);
      check("rst_cnt", cnt_o, 0);
      check("rst_bubble", bubble_count, 0);
      // Advance
      rst = 1'b1;
      ex_wd = 5'd5; ex_wdata = 32'h12345678; ex_hi = 32'hA; ex_lo = 32'hB;
      ex_aluop = 8'h23; ex_mem_addr = 32'h100; ex_reg2 = 32'h55;
      ex_hilo_temp = 64'h1234; ex_cnt = 2'd2;
      step();
      check("adv_valid", mem_valid, 1);
      check("adv_wd", mem_wd, 5);
      check("adv_wreg", mem_wreg, 1);
      check("adv_wdata", mem_wdata, 32'h12345678);
      check("adv_hi", mem_hi, 32'hA);
      check("adv_lo", mem_lo, 32'hB);
      check("adv_whilo", mem_whilo, 1);
      check("adv_aluop", mem_aluop, 8'h23);
      check("adv_addr", mem_mem_addr, 32'h100);
      check("adv_reg2", mem_reg2, 32'h55);
      check("adv_cnt", cnt_o, 0);
      check("adv_hilo_temp", hilo_temp_o, 0);
      // Bubble with feedback tracking ex_* one cycle later
      stall_ex = 1'b1; ex_cnt = 2'd1; ex_hilo_temp = 64'h0000_0001_0000_0002;
      step();
      check("bub1_cnt", cnt_o, 1);
      check("bub1_wreg", mem_wreg, 0);
      ex_cnt = 2'd2;
      step();
      check("bub2_cnt", cnt_o, 2);
      ex_cnt = 2'd1;
      step();
      check("bub3_cnt", cnt_o, 1);
      check("bub3_hilo_temp", hilo_temp_o, 64'h0000_0001_0000_0002);
      check("bub3_wreg", mem_wreg, 0);
      check("bub3_valid", mem_valid, 0);
      check("bub3_wdata", mem_wdata, 0);
      check("bub3_wd", mem_wd, 0);
      check("bub3_count", bubble_count, 3);
      check("bub3_sat_count", s_bubble, 3);
      stall_ex = 1'b0;
      step();
      check("rel_cnt", cnt_o, 0);
      check("rel_hilo_temp", hilo_temp_o, 0);
      check("rel_wdata", mem_wdata, 32'h12345678);
      // Hold
      ex_wd = 5'd7; ex_wdata = 32'hCAFEF00D;
      step();
      check("hold_pre_wd", mem_wd, 7);
      stall_ex = 1'b1; stall_mem = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ex_wdata = 32'h1000 + i; ex_wd = 5'(i); ex_cnt = 2'(i);
         step();
      end
      check("hold_wdata", mem_wdata, 32'hCAFEF00D);
      check("hold_wd", mem_wd, 7);
      check("hold_wreg", mem_wreg, 1);
      check("hold_cnt", cnt_o, 0);
      check("hold_count", bubble_count, 3);
      // Flush beats a full hold
      flush = 1'b1;
      step();
      check("flush_wreg", mem_wreg, 0);
      check("flush_wd", mem_wd, 0);
      check("flush_cnt", cnt_o, 0);
      check("flush_count", bubble_count, 3);
      // Flush beats a bubble and drops the accumulator
      flush = 1'b0; stall_mem = 1'b0; ex_cnt = 2'd2; ex_hilo_temp = 64'hABCD;
      step();
      check("bub4_cnt", cnt_o, 2);
      check("bub4_count", bubble_count, 4);
      check("bub4_sat_count", s_bubble, 3);
      flush = 1'b1;
      step();
      check("flush2_cnt", cnt_o, 0);
      check("flush2_hilo_temp", hilo_temp_o, 0);
      check("flush2_count", bubble_count, 4);
      // Saturation
      flush = 1'b0;
      step(5);
      check("sat_count", s_bubble, 3);
      check("nosat_count", bubble_count, 9);
      rst = 1'b0;
      step();
      check("rst2_count", bubble_count, 0);
      check("rst2_sat_count", s_bubble, 0);
      check("rst2_cnt", cnt_o, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
